// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared text-mode definitions for the serializer and the upstream pixel generator
// Contents: serializer state enum, glyph cell geometry (CHAR_WIDTH x CHAR_HEIGHT).
package text_pkg;

    localparam int CHAR_WIDTH  = 8;
    localparam int CHAR_HEIGHT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } text_state_e;

endpackage

// File: rtl/text_pixel_serializer.sv
// rtl/text_pixel_serializer.sv - shifts font row bytes out as one text pixel per pix_ce
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   pix_ce, line_active        : pixel strobe and text-area qualifier
//   frame_start                : restart pulse, ahead of the first text pixel
//   cur_pixels, cur_char       : font row byte and character code from the generator
//   toggle_restart/toggle_next : handshake toggles back to the generator
//   pixel_out, pixel_valid     : serialized pixel and its one-clk qualifier
//   char_out, underrun         : code being shifted, load-before-ready pulse
//   cursor_col, cursor_row     : cursor cell (only with TEXT_CURSOR_EN defined)
// Optional feature macro: TEXT_CURSOR_EN (blinking block cursor).
module text_pixel_serializer
    import text_pkg::*;
#(
    parameter int TEXT_WIDTH    = 60,
    parameter int TEXT_HEIGHT   = 20,
    parameter int FETCH_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       frame_start,
    input  logic       line_active,
    input  logic [7:0] cur_pixels,
    input  logic [7:0] cur_char,
    output logic       toggle_restart,
    output logic       toggle_next,
    output logic       pixel_out,
    output logic       pixel_valid,
    output logic [7:0] char_out,
    output logic       underrun
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [5:0] cursor_col,
    input  logic [4:0] cursor_row
`endif
);

    localparam int BW = $clog2(CHAR_WIDTH);
    localparam int PW = (FETCH_LATENCY < 1) ? 1 : $clog2(FETCH_LATENCY + 1);
    localparam logic [PW-1:0] PRIME_LOAD = PW'(FETCH_LATENCY);

    // The cursor counters are 6/5 bits wide; refuse geometries they cannot address.
    generate
        if (TEXT_WIDTH < 1 || TEXT_WIDTH > 64 || TEXT_HEIGHT < 1 || TEXT_HEIGHT > 32) begin : g_bad_geometry
            $error("text_pixel_serializer: text geometry outside 64x32 cell range");
        end
    endgenerate

    text_state_e           state;
    logic [PW-1:0]         prime_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [CHAR_WIDTH-1:0] shift;

    logic pixel_act;
    logic char_load;
    logic data_ready;
    logic load_xor;
    logic hold_xor;

    assign pixel_act  = pix_ce & line_active;
    assign char_load  = pixel_act & (bit_cnt == '0);
    // Data is only trusted once the priming window after frame_start has elapsed.
    assign data_ready = (state == ST_RUN);

`ifdef TEXT_CURSOR_EN
    logic [5:0] col_cnt;
    logic [4:0] row_cnt;
    logic [3:0] prow_cnt;
    logic       was_active;
    logic [4:0] frame_cnt;
    logic       blink;
    logic       cell_hit_q;
    logic       cell_match;

    assign cell_match = (col_cnt == cursor_col) && (row_cnt == cursor_row);
    assign load_xor   = blink & cell_match;
    assign hold_xor   = blink & cell_hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            prow_cnt   <= '0;
            was_active <= 1'b0;
            frame_cnt  <= '0;
            blink      <= 1'b0;
            cell_hit_q <= 1'b0;
        end else if (frame_start) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            prow_cnt   <= '0;
            was_active <= 1'b0;
            cell_hit_q <= 1'b0;
            frame_cnt  <= frame_cnt + 5'd1;
            // Flip on the pulse that starts each 32-frame block, so the very
            // first frame after reset already shows the cursor.
            if (frame_cnt == 5'd0) begin
                blink <= ~blink;
            end
        end else if (pix_ce) begin
            if (line_active) begin
                was_active <= 1'b1;
                if (bit_cnt == '0) begin
                    // Underrun characters are blanked, cursor included.
                    cell_hit_q <= cell_match & data_ready;
                    col_cnt    <= (col_cnt == 6'(TEXT_WIDTH - 1)) ? 6'd0 : col_cnt + 6'd1;
                end
            end else if (was_active) begin
                // First inactive pixel after a text run marks the end of a pixel line.
                was_active <= 1'b0;
                col_cnt    <= '0;
                if (prow_cnt == 4'(CHAR_HEIGHT - 1)) begin
                    prow_cnt <= '0;
                    row_cnt  <= (row_cnt == 5'(TEXT_HEIGHT - 1)) ? 5'd0 : row_cnt + 5'd1;
                end else begin
                    prow_cnt <= prow_cnt + 4'd1;
                end
            end
        end
    end
`else
    assign load_xor = 1'b0;
    assign hold_xor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            prime_cnt      <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            toggle_restart <= 1'b0;
            toggle_next    <= 1'b0;
            pixel_out      <= 1'b0;
            pixel_valid    <= 1'b0;
            char_out       <= 8'h00;
            underrun       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            underrun    <= 1'b0;

            if (frame_start) begin
                // Restart beats a coincident load: nothing is consumed this clk.
                toggle_restart <= ~toggle_restart;
                bit_cnt        <= '0;
                prime_cnt      <= PRIME_LOAD;
                state          <= ST_PRIME;
            end else begin
                if (state == ST_PRIME) begin
                    if (prime_cnt <= PW'(1)) begin
                        prime_cnt <= '0;
                        state     <= ST_RUN;
                    end else begin
                        prime_cnt <= prime_cnt - PW'(1);
                    end
                end

                if (pixel_act) begin
                    pixel_valid <= 1'b1;
                    if (char_load) begin
                        char_out    <= cur_char;
                        toggle_next <= ~toggle_next;
                        bit_cnt     <= BW'(1);
                        if (data_ready) begin
                            pixel_out <= cur_pixels[CHAR_WIDTH-1] ^ load_xor;
                            shift     <= {cur_pixels[CHAR_WIDTH-2:0], 1'b0};
                        end else begin
                            underrun  <= 1'b1;
                            pixel_out <= 1'b0;
                            shift     <= '0;
                        end
                    end else begin
                        pixel_out <= shift[CHAR_WIDTH-1] ^ hold_xor;
                        shift     <= {shift[CHAR_WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + BW'(1);
                    end
                end else if (pix_ce) begin
                    // Line end: drop any partly shifted character.
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule
